// File: rtl/tohost_exit_monitor.sv
// Snoops 32-bit writes into the 64-bit tohost mailbox, decodes the exit protocol,
// and drives harness pass/fail, an exit code, a reason and an idle-write watchdog.
//
// state | meaning
// RUN   | collecting tohost words, watchdog counting idle cycles
// EVAL  | one cycle decoding the captured command, writes stalled
// PASS  | exit code 0 reported, sticky until reset
// FAIL  | nonzero exit, bad command or watchdog timeout, sticky until reset
module tohost_exit_monitor #(
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 32'h8000_1000,
    parameter logic [31:0]       WATCHDOG_CYCLES = 32'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr_valid,
    output logic              io_wr_ready,
    input  logic [ADDR_W-1:0] io_wr_addr,
    input  logic [31:0]       io_wr_data,
    input  logic [3:0]        io_wr_mask,
    output logic              io_success,
    output logic              io_failure,
    output logic [31:0]       io_exit_code,
    output logic [1:0]        io_reason
);

    typedef enum logic [1:0] {RUN, EVAL, PASS, FAIL} state_t;

    localparam logic [ADDR_W-1:0] HI_ADDR = TOHOST_ADDR + ADDR_W'(4);
    localparam bit                WD_EN   = (WATCHDOG_CYCLES != 32'd0);

    state_t      state_q, state_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [63:0] cmd_q, cmd_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] code_q, code_d;
    logic [1:0]  reason_q, reason_d;
    logic [ADDR_W-1:0] word_addr;
    logic        accept;

    function automatic logic [31:0] merge(input logic [31:0] old_word,
                                          input logic [31:0] data,
                                          input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            lo_q     <= '0;
            hi_q     <= '0;
            cmd_q    <= '0;
            wd_q     <= '0;
            code_q   <= '0;
            reason_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cmd_q    <= cmd_d;
            wd_q     <= wd_d;
            code_q   <= code_d;
            reason_q <= reason_d;
        end
    end

    assign word_addr = io_wr_addr & ~ADDR_W'(3);
    assign accept    = io_wr_valid && io_wr_ready;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        cmd_d    = cmd_q;
        wd_d     = wd_q;
        code_d   = code_q;
        reason_d = reason_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    wd_d = '0;
                    if (word_addr == TOHOST_ADDR) begin
                        lo_d = merge(lo_q, io_wr_data, io_wr_mask);
                    end else if (word_addr == HI_ADDR) begin
                        hi_d    = merge(hi_q, io_wr_data, io_wr_mask);
                        cmd_d   = {hi_d, lo_q};
                        state_d = EVAL;
                    end
                end else if (WD_EN) begin
                    // Saturates at the limit because FAIL freezes the counter.
                    wd_d = wd_q + 32'd1;
                    if (wd_d == WATCHDOG_CYCLES) begin
                        state_d  = FAIL;
                        reason_d = 2'd3;
                        code_d   = '0;
                    end
                end
            end
            EVAL: begin
                wd_d = '0;
                if (cmd_q == 64'd0) begin
                    state_d = RUN;
                    lo_d    = '0;
                    hi_d    = '0;
                end else begin
                    code_d = cmd_q[32:1];
                    if (!cmd_q[0]) begin
                        state_d  = FAIL;
                        reason_d = 2'd2;
                    end else if (cmd_q[32:1] == 32'd0) begin
                        state_d  = PASS;
                        reason_d = 2'd0;
                    end else begin
                        state_d  = FAIL;
                        reason_d = 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign io_wr_ready  = (state_q != EVAL);
    assign io_success   = (state_q == PASS);
    assign io_failure   = (state_q == FAIL);
    assign io_exit_code = code_q;
    assign io_reason    = reason_q;

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Bench for tohost_exit_monitor: directed vector table, hand-written multi-cycle
// corners, and random traffic against a behavioural mailbox model.
module tb_tohost_exit_monitor;

    localparam logic [31:0] T = 32'h8000_1000;
    localparam logic [31:0] H = 32'h8000_1004;
    localparam logic [31:0] X = 32'h0000_2000;
    localparam int P_RUN = 0, P_EVAL = 1, P_PASS = 2, P_FAIL = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [3:0]  mask = '0;

    logic        rdy0, suc0, fail0, rdy1, suc1, fail1;
    logic [31:0] code0, code1;
    logic [1:0]  rsn0, rsn1;
    logic [36:0] o0, o1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    tohost_exit_monitor #(.ADDR_W(32), .TOHOST_ADDR(T), .WATCHDOG_CYCLES(32'd0)) dut0 (
        .clock(clock), .reset(reset), .io_wr_valid(valid), .io_wr_ready(rdy0),
        .io_wr_addr(addr), .io_wr_data(data), .io_wr_mask(mask),
        .io_success(suc0), .io_failure(fail0), .io_exit_code(code0), .io_reason(rsn0));

    tohost_exit_monitor #(.ADDR_W(32), .TOHOST_ADDR(T), .WATCHDOG_CYCLES(32'd10)) dut1 (
        .clock(clock), .reset(reset), .io_wr_valid(valid), .io_wr_ready(rdy1),
        .io_wr_addr(addr), .io_wr_data(data), .io_wr_mask(mask),
        .io_success(suc1), .io_failure(fail1), .io_exit_code(code1), .io_reason(rsn1));

    assign o0 = {rdy0, suc0, fail0, rsn0, code0};
    assign o1 = {rdy1, suc1, fail1, rsn1, code1};

    function automatic logic [36:0] ex(input logic r, input logic s, input logic f,
                                       input logic [1:0] rs, input logic [31:0] c);
        return {r, s, f, rs, c};
    endfunction

    typedef struct {
        int          phase;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] cmd;
        int unsigned idle;
        logic [31:0] code;
        logic [1:0]  reason;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.phase = P_RUN; n.lo = '0; n.hi = '0; n.cmd = '0;
        n.idle = 0; n.code = '0; n.reason = '0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input int unsigned wmax, input logic v,
                                      input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] mk);
        mdl_t n;
        logic [31:0] w;
        n = s;
        w = a & ~32'd3;
        if (s.phase == P_RUN) begin
            if (v) begin
                n.idle = 0;
                if (w == T) begin
                    for (int i = 0; i < 4; i++) if (mk[i]) n.lo[8*i +: 8] = d[8*i +: 8];
                end else if (w == H) begin
                    for (int i = 0; i < 4; i++) if (mk[i]) n.hi[8*i +: 8] = d[8*i +: 8];
                    n.cmd   = {n.hi, s.lo};
                    n.phase = P_EVAL;
                end
            end else if (wmax != 0) begin
                n.idle = s.idle + 1;
                if (n.idle >= wmax) begin
                    n.phase = P_FAIL; n.reason = 2'd3; n.code = '0;
                end
            end
        end else if (s.phase == P_EVAL) begin
            n.idle = 0;
            if (s.cmd == 64'd0) begin
                n.phase = P_RUN; n.lo = '0; n.hi = '0;
            end else begin
                n.code = 32'(s.cmd >> 1);
                if (s.cmd % 2 == 0) begin
                    n.phase = P_FAIL; n.reason = 2'd2;
                end else if (n.code == 0) begin
                    n.phase = P_PASS; n.reason = 2'd0;
                end else begin
                    n.phase = P_FAIL; n.reason = 2'd1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [36:0] mdl_out(input mdl_t s);
        return ex(s.phase != P_EVAL, s.phase == P_PASS, s.phase == P_FAIL, s.reason, s.code);
    endfunction

    task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual={rdy,suc,fail,rsn,code}=%h required=%h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; no rising edge occurs while reset is high.
    task automatic do_reset();
        valid = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();
    endtask

    task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] mk);
        valid = v; addr = a; data = d; mask = mk;
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        bit          rst;
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [36:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mv(input bit r, input logic v, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] m,
                                input logic [36:0] e);
        vec_t x;
        x.rst = r; x.v = v; x.a = a; x.d = d; x.m = m; x.exp = e;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [36:0] e_run, e_eval, e_pass;
        e_run  = ex(1, 0, 0, 2'd0, 32'd0);
        e_eval = ex(0, 0, 0, 2'd0, 32'd0);
        e_pass = ex(1, 1, 0, 2'd0, 32'd0);

        // Pass sequence, then sticky PASS under writes
        vt.push_back(mv(1, 1, T, 32'h1, 4'hF, e_run));
        vt.push_back(mv(0, 1, H, 32'h0, 4'hF, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, e_pass));
        vt.push_back(mv(0, 1, T, 32'hFFFF_FFFF, 4'hF, e_pass));
        vt.push_back(mv(0, 1, H, 32'hFFFF_FFFF, 4'hF, e_pass));
        // Nonzero exit code
        vt.push_back(mv(1, 1, T, 32'h7, 4'hF, e_run));
        vt.push_back(mv(0, 1, H, 32'h0, 4'hF, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, ex(1, 0, 1, 2'd1, 32'h3)));
        // Bad command (bit 0 clear)
        vt.push_back(mv(1, 1, T, 32'h8000_2000, 4'hF, e_run));
        vt.push_back(mv(0, 1, H, 32'h0, 4'hF, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, ex(1, 0, 1, 2'd2, 32'h4000_1000)));
        // Partial LO mask, HI bit feeds code bit 31
        vt.push_back(mv(1, 1, T, 32'hAABB_CC05, 4'b0001, e_run));
        vt.push_back(mv(0, 1, H, 32'h1, 4'hF, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, ex(1, 0, 1, 2'd1, 32'h8000_0002)));
        // Zero command returns to RUN; low address bits ignored; HI mask 0 still commits
        vt.push_back(mv(1, 1, T + 3, 32'h0, 4'hF, e_run));
        vt.push_back(mv(0, 1, H + 2, 32'h0, 4'hF, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, e_run));
        vt.push_back(mv(0, 1, T, 32'h1, 4'hF, e_run));
        vt.push_back(mv(0, 1, H, 32'hFFFF_FFFF, 4'h0, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, e_pass));
        // Other addresses ignored; HI byte lane 1 does not touch bit 32
        vt.push_back(mv(1, 1, T, 32'h1, 4'hF, e_run));
        vt.push_back(mv(0, 1, X, 32'hFFFF_FFFF, 4'hF, e_run));
        vt.push_back(mv(0, 1, H, 32'h1234_5679, 4'b0010, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, e_pass));
        // HI byte lane 0 sets bit 32
        vt.push_back(mv(1, 1, T, 32'h1, 4'hF, e_run));
        vt.push_back(mv(0, 1, H, 32'h1234_5679, 4'b0001, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, ex(1, 0, 1, 2'd1, 32'h8000_0000)));
        // Two LO writes merging bytes
        vt.push_back(mv(1, 1, T, 32'hFFFF_FFFF, 4'hF, e_run));
        vt.push_back(mv(0, 1, T, 32'h0, 4'b1110, e_run));
        vt.push_back(mv(0, 1, H, 32'h0, 4'hF, e_eval));
        vt.push_back(mv(0, 0, T, 32'h0, 4'h0, ex(1, 0, 1, 2'd1, 32'h7F)));

        m0 = mdl_reset();
        m1 = mdl_reset();
        #1 reset = 1'b1;
        @(negedge clock);
        chk("reset_vals0", o0, e_run);
        chk("reset_vals1", o1, e_run);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            drive_cycle(vt[i].v, vt[i].a, vt[i].d, vt[i].m);
            chk($sformatf("vec%0d_wd0", i), o0, vt[i].exp);
            chk($sformatf("vec%0d_wd10", i), o1, vt[i].exp);
        end

        // PASS stays frozen for 100 cycles of random writes
        do_reset();
        drive_cycle(1, T, 32'h1, 4'hF);
        drive_cycle(1, H, 32'h0, 4'hF);
        for (int i = 0; i < 100; i++) begin
            drive_cycle($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? T : H,
                        $urandom, 4'($urandom));
            chk("pass_sticky0", o0, e_pass);
            chk("pass_sticky1", o1, e_pass);
        end

        // Watchdog: fails exactly at the 10th idle edge; disabled instance never fails
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive_cycle(0, X, 32'h0, 4'h0);
            chk($sformatf("wd_idle_k%0d", k), o1,
                (k == 10) ? ex(1, 0, 1, 2'd3, 32'd0) : e_run);
        end
        chk("wd_disabled", o0, e_run);

        // Non-tohost write in cycle 9 restarts the count
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            drive_cycle(k == 9, X, 32'h5, 4'hF);
            if (k >= 9)
                chk($sformatf("wd_kick9_k%0d", k), o1,
                    (k == 19) ? ex(1, 0, 1, 2'd3, 32'd0) : e_run);
        end

        // Write in cycle 10 takes priority over expiry
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive_cycle(k == 10, X, 32'h5, 4'hF);
            if (k >= 10)
                chk($sformatf("wd_kick10_k%0d", k), o1,
                    (k == 20) ? ex(1, 0, 1, 2'd3, 32'd0) : e_run);
        end

        // Reset during EVAL clears asynchronously; next command sees lo = 0
        do_reset();
        drive_cycle(1, T, 32'h7, 4'hF);
        drive_cycle(1, H, 32'h0, 4'hF);
        chk("mid_eval_ready", o0, e_eval);
        reset = 1'b1;
        #1;
        chk("async_rst0", o0, e_run);
        chk("async_rst1", o1, e_run);
        #1 reset = 1'b0;
        drive_cycle(1, H, 32'h1, 4'hF);
        chk("fresh_eval", o0, e_eval);
        drive_cycle(0, X, 32'h0, 4'h0);
        chk("fresh_lo_zero", o0, ex(1, 0, 1, 2'd2, 32'h8000_0000));
        reset = 1'b1;
        #1;
        chk("async_rst_fail", o0, e_run);
        #1 reset = 1'b0;

        // Random traffic against the behavioural model
        for (int ep = 0; ep < 60; ep++) begin
            int unsigned vp;
            do_reset();
            vp = (ep % 3 == 0) ? 20 : ((ep % 3 == 1) ? 60 : 90);
            for (int c = 0; c < 40; c++) begin
                logic        v;
                logic [31:0] a, d;
                logic [3:0]  mk;
                int          sel;
                v   = ($urandom_range(0, 99) < vp);
                sel = $urandom_range(0, 9);
                if (sel < 4)      a = T | 32'($urandom_range(0, 3));
                else if (sel < 7) a = H | 32'($urandom_range(0, 3));
                else              a = $urandom & 32'h7FFF_FFFF;
                sel = $urandom_range(0, 3);
                d = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd1 :
                    (sel == 2) ? 32'($urandom_range(0, 15)) : $urandom;
                mk = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
                m0 = mdl_step(m0, 0, v, a, d, mk);
                m1 = mdl_step(m1, 10, v, a, d, mk);
                drive_cycle(v, a, d, mk);
                chk($sformatf("rand_e%0d_c%0d_wd0", ep, c), o0, mdl_out(m0));
                chk($sformatf("rand_e%0d_c%0d_wd10", ep, c), o1, mdl_out(m1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
